// File: rtl/joy_mux_scanner.sv
// Scans up to four DB9 joystick ports over one shared 6-bit bus, debounces each bit
// and optionally decodes Mega Drive 3-button pads into active-low {b7,b6,B2,B1,R,L,D,U}.
module joy_mux_scanner #(
    parameter int PORTS         = 2,
    parameter int MD_MODE       = 0,
    parameter int SETTLE_CYCLES = 500,
    parameter int DEBOUNCE      = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [5:0]  joy_in,
    output logic [1:0]  port_sel_o,
    output logic        md_sel_o,
    output logic [31:0] joy_out,
    output logic        frame_done
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int DW = $clog2(DEBOUNCE + 1);

    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
    localparam logic [SW-1:0] SETTLE_ONE  = SW'(1);
    localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE - 1);
    localparam logic [DW-1:0] DB_ONE      = DW'(1);
    localparam logic [1:0]    LAST_PORT   = 2'(PORTS - 1);
    localparam bit            MD_EN       = (MD_MODE != 0);

    typedef enum logic [1:0] {
        ST_SELECT = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2
    } state_e;

    state_e        state_q;
    logic [SW-1:0] settle_q;
    logic [1:0]    port_q;
    logic          phase_q;
    logic [1:0]    port_sel_q;
    logic          md_sel_q;
    logic          eval_q;
    logic [1:0]    eval_port_q;
    logic          frame_done_q;

    // Phase L keeps only {B2, B1, R, L}; U/D read in phase L carry no information.
    logic [5:0]    samp_h_q [4];
    logic [3:0]    samp_l_q [4];
    logic [7:0]    out_q    [4];
    logic [DW-1:0] cnt_q    [4][8];

    logic          last_phase_s;
    logic          next_phase_s;
    logic [1:0]    next_port_s;
    logic [5:0]    h_s;
    logic [3:0]    l_s;
    logic          detect_s;
    logic [7:0]    cand_s;

    // Next slot in scan order p0H, [p0L], p1H, ... wrapping after the last port.
    always_comb begin
        last_phase_s = MD_EN ? phase_q : 1'b1;
        next_phase_s = 1'b0;
        next_port_s  = port_q;
        if (!last_phase_s) begin
            next_phase_s = 1'b1;
            next_port_s  = port_q;
        end else if (port_q == LAST_PORT) begin
            next_port_s  = 2'd0;
        end else begin
            next_port_s  = port_q + 2'd1;
        end
    end

    // Candidate vector for the port whose last phase has just been sampled.
    always_comb begin
        h_s      = samp_h_q[eval_port_q];
        l_s      = samp_l_q[eval_port_q];
        detect_s = (l_s[0] == 1'b0) && (l_s[1] == 1'b0);
        if (MD_EN && detect_s) begin
            cand_s = {l_s[3], l_s[2], h_s};
        end else begin
            cand_s = {2'b11, h_s};
        end
    end

    // Scan sequencer: select, wait for the pins to settle, then sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_SELECT;
            settle_q    <= '0;
            port_q      <= 2'd0;
            phase_q     <= 1'b0;
            port_sel_q  <= 2'd0;
            md_sel_q    <= 1'b1;
            eval_q      <= 1'b0;
            eval_port_q <= 2'd0;
            for (int p = 0; p < 4; p++) begin
                samp_h_q[p] <= 6'h3F;
                samp_l_q[p] <= 4'hF;
            end
        end else if (!enable) begin
            state_q    <= ST_SELECT;
            port_q     <= 2'd0;
            phase_q    <= 1'b0;
            port_sel_q <= 2'd0;
            md_sel_q   <= 1'b1;
            eval_q     <= 1'b0;
        end else begin
            eval_q <= 1'b0;
            case (state_q)
                ST_SELECT: begin
                    settle_q <= SETTLE_LOAD;
                    state_q  <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_q == '0) begin
                        state_q <= ST_SAMPLE;
                    end else begin
                        settle_q <= settle_q - SETTLE_ONE;
                    end
                end
                ST_SAMPLE: begin
                    if (MD_EN && phase_q) begin
                        samp_l_q[port_q] <= joy_in[5:2];
                    end else begin
                        samp_h_q[port_q] <= joy_in;
                    end
                    eval_q      <= last_phase_s;
                    eval_port_q <= port_q;
                    port_q      <= next_port_s;
                    phase_q     <= next_phase_s;
                    port_sel_q  <= next_port_s;
                    md_sel_q    <= ~next_phase_s;
                    state_q     <= ST_SELECT;
                end
                default: begin
                    state_q <= ST_SELECT;
                end
            endcase
        end
    end

    // Per-bit debounce, run once per port per frame after its final phase.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_done_q <= 1'b0;
            for (int p = 0; p < 4; p++) begin
                out_q[p] <= 8'hFF;
                for (int b = 0; b < 8; b++) begin
                    cnt_q[p][b] <= '0;
                end
            end
        end else if (enable && eval_q) begin
            frame_done_q <= (eval_port_q == LAST_PORT);
            for (int b = 0; b < 8; b++) begin
                if (cand_s[b] == out_q[eval_port_q][b]) begin
                    cnt_q[eval_port_q][b] <= '0;
                end else if (cnt_q[eval_port_q][b] == DB_LAST) begin
                    out_q[eval_port_q][b] <= cand_s[b];
                    cnt_q[eval_port_q][b] <= '0;
                end else begin
                    cnt_q[eval_port_q][b] <= cnt_q[eval_port_q][b] + DB_ONE;
                end
            end
        end else begin
            frame_done_q <= 1'b0;
        end
    end

    assign port_sel_o = port_sel_q;
    assign md_sel_o   = md_sel_q;
    assign frame_done = frame_done_q;

    for (genvar p = 0; p < 4; p++) begin : g_out
        if (p < PORTS) begin : g_used
            assign joy_out[8*p +: 8] = out_q[p];
        end else begin : g_unused
            assign joy_out[8*p +: 8] = 8'hFF;
        end
    end

endmodule
